// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared definitions for the fetch PC generator.
// Holds the FSM state type, the sequential PC step and the default reset PC.
package pc_gen_pkg;

    // Two-state fetch controller
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pc_state_t;

    // Sequential fetch step in bytes (fixed 32-bit instructions)
    localparam int PC_INC = 4;

    // Default PC after reset, truncated to XLEN by the user
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/pc_gen_ras.sv
// pc_gen_ras: circular return-address stack for pc_gen.
// A push on a full stack overwrites the oldest entry; the count saturates at DEPTH.
// Push and pop in the same cycle replace the top entry and leave the count unchanged.
// A pop on an empty stack is ignored. DEPTH must be a power of two, >= 2.
module pc_gen_ras
    import pc_gen_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  logic [XLEN-1:0] i_push_data,
    input  logic            i_pop,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty,
    output logic            o_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   r_cnt;
    logic [XLEN-1:0]  r_mem [DEPTH];

    logic             w_pop_ok;
    logic             w_push_only;
    logic [PTR_W-1:0] w_wr_idx;

    assign w_pop_ok    = i_pop && (r_cnt != '0);
    assign w_push_only = i_push && !w_pop_ok;
    // A lone push writes one slot above the top; push+pop overwrites the top itself
    assign w_wr_idx    = w_push_only ? (r_ptr + PTR_W'(1)) : r_ptr;

    assign o_top   = r_mem[r_ptr];
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (PTR_W + 1)'(DEPTH));

    // Track top-of-stack pointer and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_push_only) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (r_cnt != (PTR_W + 1)'(DEPTH)) begin
                r_cnt <= r_cnt + (PTR_W + 1)'(1);
            end
        end else if (w_pop_ok && !i_push) begin
            r_ptr <= r_ptr - PTR_W'(1);
            r_cnt <= r_cnt - (PTR_W + 1)'(1);
        end
    end

    // Store return addresses; storage needs no reset since occupancy guards reads
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with RUN/HALTED control.
// Next-PC priority in RUN: jalr > taken branch > halt > return-stack prediction
// > sequential (+4 on handshake) > hold. All outputs are registered.
// Optional return-address stack enabled by defining PC_GEN_RAS_EN; without it the
// call/return ports are ignored and ras_hit_o is tied low.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    input  logic            pc_ready_i,
    input  logic            jalr_i,
    input  logic [XLEN-1:0] jalr_target_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_base_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic            halted_o,
    output logic            misalign_o,
    input  logic            call_i,
    input  logic [XLEN-1:0] call_addr_i,
    input  logic            pred_ret_i,
    output logic            ras_hit_o
);

    pc_state_t       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_halted;
    logic            r_misalign;

    logic            w_run;
    logic            w_fire;
    logic            w_redirect;
    logic [XLEN-1:0] w_jalr_pc;
    logic [XLEN-1:0] w_br_pc;
    logic [XLEN-1:0] w_seq_pc;
    logic            w_ras_take;
    logic [XLEN-1:0] w_ras_top;
    logic            w_unused;

    assign w_run      = (r_state == ST_RUN);
    assign w_fire     = r_pc_valid && pc_ready_i;
    assign w_redirect = jalr_i || br_taken_i;
    assign w_jalr_pc  = {jalr_target_i[XLEN-1:1], 1'b0};
    assign w_br_pc    = br_base_i + imm_i;
    assign w_seq_pc   = r_pc + XLEN'(PC_INC);

`ifdef PC_GEN_RAS_EN
    logic w_ras_pop;
    logic w_ras_empty;
    logic w_ras_full;
    logic r_ras_hit;
    logic w_unused_ras;

    // A return consumed by fetch pops the stack unless a halt holds the PC;
    // a same-cycle redirect still pops but overrides the predicted target
    assign w_ras_pop    = w_run && w_fire && pred_ret_i && !w_ras_empty
                          && (w_redirect || !halt_i);
    assign w_ras_take   = w_ras_pop && !w_redirect;
    assign w_unused_ras = w_ras_full;

    pc_gen_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .i_push      (call_i),
        .i_push_data (call_addr_i),
        .i_pop       (w_ras_pop),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty),
        .o_full      (w_ras_full)
    );

    // Flag for one cycle that the PC was just loaded from the return stack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ras_hit <= 1'b0;
        end else begin
            r_ras_hit <= w_ras_take;
        end
    end

    assign ras_hit_o = r_ras_hit;
    assign w_unused  = jalr_target_i[0];
`else
    assign w_ras_take = 1'b0;
    assign w_ras_top  = '0;
    assign ras_hit_o  = 1'b0;
    assign w_unused   = ^{jalr_target_i[0], call_i, call_addr_i, pred_ret_i, 1'(RAS_DEPTH)};
`endif

    // Run/halt controller and next-PC selection with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_halted   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_pc_valid <= 1'b1;
                    if (jalr_i) begin
                        r_pc       <= w_jalr_pc;
                        r_misalign <= w_jalr_pc[1];
                    end else if (br_taken_i) begin
                        r_pc       <= w_br_pc;
                        r_misalign <= w_br_pc[1];
                    end else if (halt_i) begin
                        r_state    <= ST_HALTED;
                        r_pc_valid <= 1'b0;
                        r_halted   <= 1'b1;
                    end else if (w_ras_take) begin
                        r_pc <= w_ras_top;
                    end else if (w_fire) begin
                        r_pc <= w_seq_pc;
                    end
                end
                ST_HALTED: begin
                    if (resume_i && !halt_i) begin
                        r_state    <= ST_RUN;
                        r_pc_valid <= 1'b1;
                        r_halted   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_pc_valid <= 1'b1;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o       = r_pc;
    assign pc_valid_o = r_pc_valid;
    assign halted_o   = r_halted;
    assign misalign_o = r_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: table-driven self-checking bench for pc_gen with an in-order scoreboard.
// Return-stack sequences are selected by PC_GEN_RAS_EN to match the DUT build.
module tb_pc_gen;

    localparam int          XLEN = 64;
    localparam logic [63:0] RPC  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic        jalr;
        logic [63:0] tgt;
        logic        br;
        logic [63:0] base;
        logic [63:0] imm;
        logic        ready;
        logic        halt;
        logic        resume;
        logic        call;
        logic [63:0] caddr;
        logic        pred;
        logic [63:0] e_pc;
        logic        e_valid;
        logic        e_halted;
        logic        e_mis;
        logic        e_hit;
    } vec_t;

    logic            clk;
    logic            reset;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic            pc_ready_i;
    logic            jalr_i;
    logic [XLEN-1:0] jalr_target_i;
    logic            br_taken_i;
    logic [XLEN-1:0] br_base_i;
    logic [XLEN-1:0] imm_i;
    logic            halt_i;
    logic            resume_i;
    logic            halted_o;
    logic            misalign_o;
    logic            call_i;
    logic [XLEN-1:0] call_addr_i;
    logic            pred_ret_i;
    logic            ras_hit_o;

    int   n_checks;
    int   n_errors;
    vec_t sb[$];
    vec_t tbl[27];

    pc_gen #(
        .XLEN      (XLEN),
        .RESET_PC  (RPC),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_o          (pc_o),
        .pc_valid_o    (pc_valid_o),
        .pc_ready_i    (pc_ready_i),
        .jalr_i        (jalr_i),
        .jalr_target_i (jalr_target_i),
        .br_taken_i    (br_taken_i),
        .br_base_i     (br_base_i),
        .imm_i         (imm_i),
        .halt_i        (halt_i),
        .resume_i      (resume_i),
        .halted_o      (halted_o),
        .misalign_o    (misalign_o),
        .call_i        (call_i),
        .call_addr_i   (call_addr_i),
        .pred_ret_i    (pred_ret_i),
        .ras_hit_o     (ras_hit_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkv(
        input logic jalr, input logic [63:0] tgt, input logic br, input logic [63:0] base,
        input logic [63:0] imm, input logic ready, input logic halt, input logic resume,
        input logic call, input logic [63:0] caddr, input logic pred,
        input logic [63:0] e_pc, input logic e_valid, input logic e_halted,
        input logic e_mis, input logic e_hit);
        vec_t v;
        v.jalr = jalr; v.tgt = tgt; v.br = br; v.base = base; v.imm = imm;
        v.ready = ready; v.halt = halt; v.resume = resume;
        v.call = call; v.caddr = caddr; v.pred = pred;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_halted = e_halted;
        v.e_mis = e_mis; v.e_hit = e_hit;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        jalr_i        = v.jalr;
        jalr_target_i = v.tgt;
        br_taken_i    = v.br;
        br_base_i     = v.base;
        imm_i         = v.imm;
        pc_ready_i    = v.ready;
        halt_i        = v.halt;
        resume_i      = v.resume;
        call_i        = v.call;
        call_addr_i   = v.caddr;
        pred_ret_i    = v.pred;
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge
    task automatic apply(input vec_t v, input string tag, input int idx);
        vec_t e;
        drive(v);
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s[%0d] scoreboard empty got %h want entry", tag, idx, pc_o);
        end else begin
            e = sb.pop_front();
            chk({tag, ".pc"}, idx, pc_o, e.e_pc);
            chk({tag, ".valid"}, idx, 64'(pc_valid_o), 64'(e.e_valid));
            chk({tag, ".halted"}, idx, 64'(halted_o), 64'(e.e_halted));
            chk({tag, ".misalign"}, idx, 64'(misalign_o), 64'(e.e_mis));
            chk({tag, ".ras_hit"}, idx, 64'(ras_hit_o), 64'(e.e_hit));
        end
    endtask

    function automatic vec_t idle(input logic ready, input logic [63:0] e_pc);
        return mkv(0, 0, 0, 0, 0, ready, 0, 0, 0, 0, 0, e_pc, 1, 0, 0, 0);
    endfunction

    function automatic vec_t callv(input logic [63:0] a, input logic [63:0] e_pc);
        return mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, a, 0, e_pc, 1, 0, 0, 0);
    endfunction

    function automatic vec_t retv(input logic [63:0] e_pc, input logic e_hit);
        return mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, e_pc, 1, 0, 0, e_hit);
    endfunction

    initial begin
        vec_t v;
        n_checks = 0;
        n_errors = 0;

        // jalr tgt br base imm rdy halt res call caddr pred | pc valid halted mis hit
        tbl[0]  = mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, RPC, 1, 0, 0, 0);
        tbl[1]  = idle(1, RPC + 64'h4);
        tbl[2]  = idle(1, RPC + 64'h8);
        tbl[3]  = idle(1, RPC + 64'hC);
        tbl[4]  = idle(0, RPC + 64'hC);
        tbl[5]  = mkv(1, 64'h1001, 1, 64'h10, 64'h20, 1, 0, 0, 0, 0, 0, 64'h1000, 1, 0, 0, 0);
        tbl[6]  = mkv(0, 0, 1, 64'h10, ALL1 - 64'h7, 0, 0, 0, 0, 0, 0, 64'h8, 1, 0, 0, 0);
        tbl[7]  = mkv(0, 0, 1, 64'h0, 64'h6, 0, 0, 0, 0, 0, 0, 64'h6, 1, 0, 1, 0);
        tbl[8]  = idle(0, 64'h6);
        tbl[9]  = mkv(1, RPC + 64'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0, RPC + 64'h12, 1, 0, 1, 0);
        tbl[10] = mkv(1, RPC + 64'h10, 0, 0, 0, 1, 0, 0, 0, 0, 0, RPC + 64'h10, 1, 0, 0, 0);
        tbl[11] = mkv(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, RPC + 64'h10, 0, 1, 0, 0);
        tbl[12] = mkv(1, 64'h2000, 1, 64'h40, 64'h4, 1, 0, 0, 0, 0, 0, RPC + 64'h10, 0, 1, 0, 0);
        tbl[13] = mkv(0, 0, 1, 64'h40, 64'h4, 1, 0, 0, 0, 0, 0, RPC + 64'h10, 0, 1, 0, 0);
        tbl[14] = mkv(0, 0, 1, 64'h40, 64'h4, 1, 0, 0, 0, 0, 1, RPC + 64'h10, 0, 1, 0, 0);
        tbl[15] = mkv(0, 0, 1, 64'h40, 64'h4, 1, 0, 0, 0, 0, 0, RPC + 64'h10, 0, 1, 0, 0);
        tbl[16] = mkv(0, 0, 1, 64'h40, 64'h4, 1, 0, 0, 0, 0, 0, RPC + 64'h10, 0, 1, 0, 0);
        tbl[17] = mkv(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, RPC + 64'h10, 0, 1, 0, 0);
        tbl[18] = mkv(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, RPC + 64'h10, 1, 0, 0, 0);
        tbl[19] = idle(1, RPC + 64'h14);
        tbl[20] = mkv(0, 0, 1, 64'h100, 64'h0, 1, 1, 0, 0, 0, 0, 64'h100, 1, 0, 0, 0);
        tbl[21] = idle(1, 64'h104);
        tbl[22] = mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 64'h108, 1, 0, 0, 0);
        tbl[23] = mkv(1, ALL1 - 64'h3, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL1 - 64'h3, 1, 0, 0, 0);
        tbl[24] = idle(1, 64'h0);
        tbl[25] = mkv(0, 0, 1, ALL1 - 64'hF, 64'h22, 0, 0, 0, 0, 0, 0, 64'h12, 1, 0, 1, 0);
        tbl[26] = idle(0, 64'h12);

        // Reset state while reset is held
        drive(idle(0, 0));
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.pc", 0, pc_o, RPC);
        chk("rst.valid", 0, 64'(pc_valid_o), 64'h0);
        chk("rst.halted", 0, 64'(halted_o), 64'h0);
        chk("rst.misalign", 0, 64'(misalign_o), 64'h0);
        chk("rst.ras_hit", 0, 64'(ras_hit_o), 64'h0);
        reset = 1'b0;

        for (int i = 0; i < 27; i++) begin
            apply(tbl[i], "vec", i);
        end

        // Reset arriving while halted aborts the halt immediately
        apply(mkv(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 64'h12, 0, 1, 0, 0), "rhalt", 0);
        reset = 1'b1;
        #1;
        chk("rhalt.pc", 1, pc_o, RPC);
        chk("rhalt.halted", 1, 64'(halted_o), 64'h0);
        chk("rhalt.valid", 1, 64'(pc_valid_o), 64'h0);
        // A redirect presented under reset must not load
        drive(mkv(1, 64'h3000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("rjalr.pc", 0, pc_o, RPC);
        chk("rjalr.misalign", 0, 64'(misalign_o), 64'h0);
        reset = 1'b0;
        apply(idle(0, RPC), "rrel", 0);

`ifdef PC_GEN_RAS_EN
        // Five calls into a four-deep stack: 0x100 is overwritten
        for (int i = 1; i <= 5; i++) begin
            apply(callv(64'(i) << 8, RPC), "push", i);
        end
        apply(retv(64'h500, 1), "pop", 0);
        apply(retv(64'h400, 1), "pop", 1);
        apply(retv(64'h300, 1), "pop", 2);
        apply(retv(64'h200, 1), "pop", 3);
        apply(retv(64'h204, 0), "pop", 4);
        // Push and pop together replace the top without changing depth
        apply(callv(64'hA00, 64'h204), "pp", 0);
        v = retv(64'hA00, 1);
        v.call = 1'b1;
        v.caddr = 64'hB00;
        apply(v, "pp", 1);
        apply(retv(64'hB00, 1), "pp", 2);
        apply(retv(64'hB04, 0), "pp", 3);
        // Redirect overrides a prediction but the pop still happens
        apply(callv(64'hC00, 64'hB04), "ovr", 0);
        v = retv(64'h2000, 0);
        v.jalr = 1'b1;
        v.tgt = 64'h2000;
        apply(v, "ovr", 1);
        apply(retv(64'h2004, 0), "ovr", 2);
`else
        // Without the stack, calls and returns do not affect the PC
        apply(callv(64'h100, RPC), "noras", 0);
        apply(callv(64'h200, RPC), "noras", 1);
        apply(retv(RPC + 64'h4, 0), "noras", 2);
        apply(retv(RPC + 64'h8, 0), "noras", 3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameters: XLEN, 64, PC/address width; RESET_PC, 64'h8000_0000 (truncated to XLEN), PC after reset; RAS_DEPTH, 4, return-stack entries (power of two, >=2).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge;
- reset  in  1  asynchronous, active-high;
- pc_o  out  XLEN  current fetch PC;
- pc_valid_o  out  1  pc_o valid for fetch;
- pc_ready_i  in  1  fetch accepts pc_o;
- jalr_i  in  1  execute jalr redirect;
- jalr_target_i  in  XLEN  ALU result for jalr;
- br_taken_i  in  1  jal or taken branch;
- br_base_i  in  XLEN  PC of branching instruction;
- imm_i  in  XLEN  sign-extended offset;
- halt_i  in  1  halt request;
- resume_i  in  1  leave halt;
- halted_o  out  1  in HALTED state;
- misalign_o  out  1  redirect target not 4-byte aligned;
- call_i  in  1  push return address;
- call_addr_i  in  XLEN  address pushed;
- pred_ret_i  in  1  fetched instruction at pc_o is a return;
- ras_hit_o  out  1  last PC update came from the return stack.

Function
REQ-003 SHALL keep a two-state FSM: RUN (pc_valid_o=1), HALTED (pc_valid_o=0, halted_o=1).
REQ-004 SHALL in RUN compute the next PC with priority: jalr_i > br_taken_i > halt_i > RAS prediction > sequential > hold.
REQ-005 SHALL on jalr_i load pc_o <= jalr_target_i with bit 0 cleared, next edge, regardless of pc_ready_i.
REQ-006 SHALL on br_taken_i (no jalr_i) load pc_o <= br_base_i + imm_i modulo 2^XLEN, regardless of pc_ready_i.
REQ-007 SHALL on halt_i with no redirect hold pc_o and enter HALTED next edge; a redirect in the same cycle wins and halt_i is dropped.
REQ-008 SHALL advance pc_o <= pc_o + 4 (wrapping at 2^XLEN) only when pc_valid_o && pc_ready_i and no higher-priority event; otherwise pc_o holds.
REQ-009 SHALL in HALTED ignore jalr_i, br_taken_i, pred_ret_i and pc_ready_i; resume_i returns to RUN next edge with pc_o unchanged; halt_i and resume_i together keep HALTED.
REQ-010 SHALL pulse misalign_o for exactly one cycle, the cycle after a redirect whose loaded target has bit 1 set; the PC is still loaded.
REQ-011 SHALL make all outputs registered; no combinational path from inputs to outputs.

Reset
REQ-012 SHALL on reset assert: pc_o=RESET_PC, state RUN, pc_valid_o=1 from the first edge after deassertion (0 while reset high), halted_o=0, misalign_o=0, ras_hit_o=0, RAS empty.
REQ-013 SHALL abort any in-progress halt or redirect on reset mid-operation; no partial update survives.

Configuration
REQ-014 SHALL with PC_GEN_RAS_EN defined: call_i pushes call_addr_i; pred_ret_i with handshake and non-empty stack loads pc_o <= top, pops, and sets ras_hit_o for one cycle; push on full overwrites the oldest entry (circular pointer, count saturates at RAS_DEPTH); pred_ret_i on empty falls back to sequential; push and pop in the same cycle replace top, count unchanged; jalr_i/br_taken_i override the prediction but the pop/push still occur.
REQ-015 SHALL without PC_GEN_RAS_EN keep all ports, ignore call_i/call_addr_i/pred_ret_i, tie ras_hit_o to 0 and instantiate no stack storage.

Structure
REQ-016 SHALL place the FSM state typedef, the PC increment constant (4) and the default RESET_PC in the shared core package.
REQ-017 SHALL implement the return stack as sub-module pc_gen_ras (push, pop, top, empty, full), instantiated only under PC_GEN_RAS_EN.

Verification
REQ-018 Reset, then pc_ready_i=1 for 3 cycles -> pc_o 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C.
REQ-019 jalr_i=1, jalr_target_i=0x1001, br_taken_i=1 same cycle -> pc_o=0x1000 next edge, misalign_o=0.
REQ-020 br_base_i=0x10, imm_i=-8 (all ones upper), pc_ready_i=0 -> pc_o=0x8 next edge; br_base_i=0x0, imm_i=0x6 -> pc_o=0x6, misalign_o pulses one cycle.
REQ-021 halt_i=1 at pc_o=0x8000_0010 -> halted_o=1, pc_valid_o=0, pc_o holds through 5 cycles of br_taken_i; resume_i -> RUN, pc_o=0x8000_0010.
REQ-022 With PC_GEN_RAS_EN, RAS_DEPTH=4: push 0x100..0x500 (5 calls), then 5 pred_ret_i with handshake -> pc_o 0x500, 0x400, 0x300, 0x200, then sequential +4 (empty); ras_hit_o set on the first four only.
